period_counter_mc: RTL and testbench
====================================

# period_counter_mc

Multi-channel period counter: the parametrised successor of the single-channel coarse counter. It measures, in `clk` cycles, the interval between consecutive selected edges on each of `NUM_CH` asynchronous inputs (1PPS, GPS, oscillator-divided references). It holds one result per channel and streams results through a round-robin valid/ready port to the timestamp/discipline logic. Additions over the previous generation:
- per-channel edge mode;
- input synchronisation;
- first-edge discard;
- saturation/overflow flagging;
- overrun detection.

## Interface
- `NUM_CH`, 4: number of input channels (1..16).
- `CNT_W`, 32: period counter and result width (8..48).
- `SYNC_STAGES`, 2: synchroniser flops per input (2..4).

- `clk`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous and active-low. Asserting it clears all state immediately; release is synchronous to `clk`.
- `sig_in`  in  NUM_CH: asynchronous inputs to be measured.
- `ch_en`  in  NUM_CH: per-channel enable. 0 holds that channel idle.
- `edge_mode`  in  2*NUM_CH: per-channel edge select, channel i at bits [2i+1:2i]. 00 = rising, 01 = falling, 10 = both, 11 = reserved, behaves as rising.
- `out_valid`  out  1: a result is presented.
- `out_ready`  in  1: consumer accepts the result.
- `out_ch`  out  $clog2(NUM_CH) (min 1): channel index of the presented result.
- `out_period`  out  CNT_W: measured period in `clk` cycles.
- `out_flags`  out  2: bit0 OVF (counter saturated), bit1 OVR (an earlier unread result was overwritten).
- `edge_pulse`  out  NUM_CH: one-cycle pulse per detected edge, for local debug/LED.

## Operation
- Each channel passes `sig_in[i]` through `SYNC_STAGES` flops, then one history flop. An edge is detected by comparing the last two samples against `edge_mode`.
- Per-channel counter `cnt`:
  - increments every cycle while the channel is enabled;
  - on an edge, loads 1 and the old `cnt` is captured as the period. Two edges N cycles apart yield period N.
  - saturates at 2^CNT_W-1 and never wraps. A capture taken from a saturated counter carries OVF=1 and period 2^CNT_W-1.
- Arming: after reset or after `ch_en` rises, the first edge only restarts `cnt` and produces no result. Every later edge produces a result.
- Pending slot: each channel holds one result (period, OVF, OVR, pending bit).
  - A capture into an occupied slot overwrites it with the newer period and sets OVR=1.
  - OVR clears when that slot is granted.
- Disabling a channel (`ch_en`=0) does the following:
  - clears its pending slot, counter and armed state;
  - suppresses `edge_pulse`;
  - leaves a result already presented on the output unaffected.
- Arbiter:
  - round-robin over channels with pending results, starting after the last granted channel; after reset, channel 0 has priority;
  - a grant moves the slot contents into the output register and clears the pending bit.
- Same-cycle grant and new capture on one channel: the grant takes the old contents, and the new capture lands in the now-empty slot with OVR=0.

## Timing
- Reset values: `out_valid`=0, `out_ch`=0, `out_period`=0, `out_flags`=0, `edge_pulse`=0, all counters 0, all slots empty, all channels unarmed, round-robin pointer at channel 0.
- Input-to-edge latency: `sig_in` transition to `edge_pulse` is SYNC_STAGES+1 cycles. `cnt` reloads on the same cycle as `edge_pulse`, and the slot is written at the next clock edge.
- Slot-to-output: 1 cycle when the output register is empty or being drained.
- Handshake:
  - transfer occurs when `out_valid` && `out_ready` at a rising edge;
  - while `out_valid`=1 and `out_ready`=0, `out_ch`, `out_period` and `out_flags` are held stable;
  - `out_valid` never drops without a transfer.
- Throughput: one result per cycle sustained. On the cycle of a transfer the next grant loads the output register, so there are no bubbles.
- Minimum resolvable period: 1 cycle in both-edge mode with a synchronised toggle every cycle.
- Reset mid-operation: all state returns to reset values asynchronously. Any result in flight is lost.

## Structure
- Package `period_counter_pkg`:
  - edge-mode encoding constants (`EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`);
  - flag bit indices (`FLG_OVF`=0, `FLG_OVR`=1);
  - a packed result struct {period, ovf, ovr}.
- Sub-module `period_channel`: synchroniser, edge detect, counter, arming, and pending slot. One instance per channel, generated.
- Top: `ch_en`/`edge_mode` fan-out, round-robin arbiter, output register.

## Test plan
- Reset and first-edge discard:
  - stimulus: ch0 rising mode, edges every 1000 cycles, `out_ready`=1;
  - response: the first edge produces no output; subsequent results are ch=0, period=1000, flags=00.
- Edge modes:
  - stimulus: ch1 in both-edge mode with a 300-high/700-low waveform, then switched to falling mode;
  - response: results alternate 300 and 700 in both-edge mode, then report 1000 in falling mode.
- Saturation:
  - stimulus: CNT_W=8, edges 400 cycles apart;
  - response: period=255, OVF=1.
- Overrun and backpressure:
  - stimulus: `out_ready`=0 while ch2 sees three edges;
  - response: exactly one result per channel is presented and held stable. The held result is the first capture (OVR=0); once drained, the slot yields the latest period with OVR=1.
- Round-robin fairness:
  - stimulus: all 4 channels capture on the same cycle, `out_ready`=1;
  - response: outputs come in order ch0, ch1, ch2, ch3 on consecutive cycles. A repeat starts after ch3.
- Async reset and disable:
  - stimulus: assert `rst` while `out_valid`=1 and the slots are full; separately, drop `ch_en[0]` with a result pending;
  - response: reset drives all outputs to 0 immediately. The ch0 pending result is discarded, and ch0 needs two edges after re-enable before it produces a result.

Source files
------------

// File: rtl/period_counter_pkg.sv
// Shared definitions for the multi-channel period counter: edge-mode
// encodings, flag bit positions, the per-channel result record and edge matching.
package period_counter_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  localparam int FLG_OVF = 0;
  localparam int FLG_OVR = 1;

  // Widest supported counter; narrower channels zero-extend into it.
  localparam int PERIOD_MAX_W = 48;

  typedef struct packed {
    logic [PERIOD_MAX_W-1:0] period;
    logic                    ovf;
    logic                    ovr;
  } result_t;

  function automatic logic edge_match(input logic [1:0] mode,
                                      input logic       prev,
                                      input logic       cur);
    logic rise_v;
    logic fall_v;
    logic hit_v;
    rise_v = cur & ~prev;
    fall_v = prev & ~cur;
    case (mode)
      EDGE_FALL: hit_v = fall_v;
      EDGE_BOTH: hit_v = rise_v | fall_v;
      default:   hit_v = rise_v;
    endcase
    return hit_v;
  endfunction

endpackage

// File: rtl/period_counter_mc_channel.sv
// One measurement channel: input synchroniser, edge detect, saturating
// period counter with first-edge arming, and a single-entry result slot.
module period_channel
  import period_counter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       grant,
  output logic       pend,
  output result_t    slot,
  output logic       edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   edge_s;
  logic                   edge_pulse_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cap_period_r;
  logic                   cap_vld_r;
  logic                   armed_r;
  logic                   pend_r;
  result_t                slot_r;

  // Synchroniser and history keep running while disabled so no stale edge appears on enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge qualification against the selected mode.
  always_comb begin
    edge_s = 1'b0;
    if (en) begin
      edge_s = edge_match(mode, hist_r, sync_r[SYNC_STAGES-1]);
    end else begin
      edge_s = 1'b0;
    end
  end

  // Counter, arming and capture stage; the captured period is committed to the slot next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= '0;
      cap_period_r <= '0;
      cap_vld_r    <= 1'b0;
      armed_r      <= 1'b0;
      edge_pulse_r <= 1'b0;
    end else if (!en) begin
      cnt_r        <= '0;
      cap_vld_r    <= 1'b0;
      armed_r      <= 1'b0;
      edge_pulse_r <= 1'b0;
    end else begin
      edge_pulse_r <= edge_s;
      cap_vld_r    <= edge_s & armed_r;
      if (edge_s) begin
        cnt_r        <= CNT_ONE;
        cap_period_r <= cnt_r;
        armed_r      <= 1'b1;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Pending slot: a capture wins over a same-cycle grant, which has already taken the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 1'b0;
      slot_r <= '0;
    end else if (!en) begin
      pend_r <= 1'b0;
      slot_r <= '0;
    end else if (cap_vld_r) begin
      pend_r        <= 1'b1;
      slot_r.period <= PERIOD_MAX_W'(cap_period_r);
      slot_r.ovf    <= (cap_period_r == CNT_MAX);
      slot_r.ovr    <= pend_r & ~grant;
    end else if (grant) begin
      pend_r     <= 1'b0;
      slot_r.ovr <= 1'b0;
    end
  end

  assign pend       = pend_r;
  assign slot       = slot_r;
  assign edge_pulse = edge_pulse_r;

endmodule

// File: rtl/period_counter_mc.sv
// Multi-channel period counter top: per-channel instances, round-robin
// arbitration of pending results, and a valid/ready output register.
module period_counter_mc
  import period_counter_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   sig_in,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [2*NUM_CH-1:0] edge_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [CNT_W-1:0]    out_period,
  output logic [1:0]          out_flags,
  output logic [NUM_CH-1:0]   edge_pulse
);

  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] grant_s;
  result_t           slot_s [NUM_CH];
  result_t           sel_res_s;
  logic              load_s;
  logic              found_s;
  logic              hit_s;
  logic [CH_W:0]     rr_sum_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W-1:0]   ptr_r;
  logic              out_valid_r;
  logic [CH_W-1:0]   out_ch_r;
  logic [CNT_W-1:0]  out_period_r;
  logic [1:0]        out_flags_r;
  logic              unused_sel_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    period_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sig        (sig_in[i]),
      .en         (ch_en[i]),
      .mode       (edge_mode[2*i+1:2*i]),
      .grant      (grant_s[i]),
      .pend       (pend_s[i]),
      .slot       (slot_s[i]),
      .edge_pulse (edge_pulse[i])
    );
  end

  // Output register may take a new result when empty or draining this cycle.
  assign load_s = ~out_valid_r | out_ready;

  // Round-robin search starting at ptr_r, the channel after the last grant.
  always_comb begin
    found_s   = 1'b0;
    hit_s     = 1'b0;
    rr_sum_s  = '0;
    gnt_idx_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_sum_s  = {1'b0, ptr_r} + (CH_W+1)'(k);
      rr_sum_s  = (rr_sum_s >= (CH_W+1)'(NUM_CH)) ? rr_sum_s - (CH_W+1)'(NUM_CH) : rr_sum_s;
      hit_s     = pend_s[rr_sum_s[CH_W-1:0]] & ~found_s;
      gnt_idx_s = hit_s ? rr_sum_s[CH_W-1:0] : gnt_idx_s;
      found_s   = found_s | hit_s;
    end
  end

  // One-hot grant back to the selected channel.
  always_comb begin
    grant_s = '0;
    if (load_s && found_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign sel_res_s    = slot_s[gnt_idx_s];
  assign unused_sel_s = ^sel_res_s.period;

  // Round-robin pointer moves past each granted channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (load_s && found_s) begin
      ptr_r <= (gnt_idx_s == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_s + 1'b1;
    end
  end

  // Output register: holds while stalled, reloads on the transfer cycle for gapless streaming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r  <= 1'b0;
      out_ch_r     <= '0;
      out_period_r <= '0;
      out_flags_r  <= '0;
    end else if (load_s && found_s) begin
      out_valid_r           <= 1'b1;
      out_ch_r              <= gnt_idx_s;
      out_period_r          <= sel_res_s.period[CNT_W-1:0];
      out_flags_r[FLG_OVF]  <= sel_res_s.ovf;
      out_flags_r[FLG_OVR]  <= sel_res_s.ovr;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_ch     = out_ch_r;
  assign out_period = out_period_r;
  assign out_flags  = out_flags_r;

endmodule

// File: tb/tb_period_counter_mc.sv
// Directed bench for period_counter_mc with a result scoreboard: expected
// results are queued as edges are driven and matched on each output transfer.
module tb_period_counter_mc;
  import period_counter_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 10;
  localparam int SYNC   = 2;
  localparam int CH_W   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_CH-1:0]   sig_in = '0;
  logic [NUM_CH-1:0]   ch_en = '0;
  logic [2*NUM_CH-1:0] edge_mode = '0;
  logic                out_ready = 1'b1;
  logic                out_valid;
  logic [CH_W-1:0]     out_ch;
  logic [CNT_W-1:0]    out_period;
  logic [1:0]          out_flags;
  logic [NUM_CH-1:0]   edge_pulse;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic [1:0]       flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  period_counter_mc #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .ch_en      (ch_en),
    .edge_mode  (edge_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_period (out_period),
    .out_flags  (out_flags),
    .edge_pulse (edge_pulse)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      check("unexpected_output", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_ch", 32'(out_ch), 32'(e.ch));
        check("sb_period", 32'(out_period), 32'(e.period));
        check("sb_flags", 32'(out_flags), 32'(e.flags));
      end
    end
  end

  task automatic push(input int ch, input int period, input int flags);
    exp_t e;
    e.ch     = CH_W'(ch);
    e.period = CNT_W'(period);
    e.flags  = 2'(flags);
    sb_q.push_back(e);
  endtask

  // Returns at 2 time units after the posedge on which cyc reaches c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic tick(input int n);
    wait_until(cyc + n);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check({"drain_", tag}, 32'(sb_q.size()), 32'd0);
    tick(20);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ch"}, 32'(out_ch), 32'd0);
    check({tag, "_period"}, 32'(out_period), 32'd0);
    check({tag, "_flags"}, 32'(out_flags), 32'd0);
    check({tag, "_edge_pulse"}, 32'(edge_pulse), 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    logic pulse_seen;

    // Reset state
    #3 rst = 1'b0;
    #20;
    check_outputs_zero("reset");
    @(posedge clk);
    #2 rst = 1'b1;
    tick(5);

    // ch0 rising, 1000-cycle period; first edge only arms
    ch_en = 4'b0001;
    edge_mode = 8'h00;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);
    sig_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("pulse_lat_early", 32'(edge_pulse[0]), 32'd0);
    @(negedge clk);
    check("pulse_lat_hit", 32'(edge_pulse[0]), 32'd1);
    @(negedge clk);
    check("pulse_lat_after", 32'(edge_pulse[0]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      wait_until(t0 + 1000*k - 500);
      sig_in[0] = 1'b0;
      wait_until(t0 + 1000*k);
      sig_in[0] = 1'b1;
      push(0, 1000, 0);
    end
    drain("ch0_rise", 50);

    // ch1 both-edge 300/700, then falling mode
    ch_en = 4'b0010;
    edge_mode[3:2] = EDGE_BOTH;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);        sig_in[1] = 1'b1;
    wait_until(t0 + 300);  sig_in[1] = 1'b0; push(1, 300, 0);
    wait_until(t0 + 1000); sig_in[1] = 1'b1; push(1, 700, 0);
    wait_until(t0 + 1300); sig_in[1] = 1'b0; push(1, 300, 0);
    wait_until(t0 + 1500); edge_mode[3:2] = EDGE_FALL;
    wait_until(t0 + 2000); sig_in[1] = 1'b1;
    wait_until(t0 + 2300); sig_in[1] = 1'b0; push(1, 1000, 0);
    wait_until(t0 + 3000); sig_in[1] = 1'b1;
    wait_until(t0 + 3300); sig_in[1] = 1'b0; push(1, 1000, 0);
    drain("ch1_modes", 50);

    // ch2 overrun under backpressure
    ch_en = 4'b0100;
    edge_mode = 8'h00;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);        sig_in[2] = 1'b1;
    wait_until(t0 + 50);   sig_in[2] = 1'b0;
    wait_until(t0 + 60);   out_ready = 1'b0;
    wait_until(t0 + 200);  sig_in[2] = 1'b1;
    wait_until(t0 + 250);  sig_in[2] = 1'b0;
    wait_until(t0 + 400);
    check("held_valid_a", 32'(out_valid), 32'd1);
    check("held_period_a", 32'(out_period), 32'd200);
    wait_until(t0 + 500);  sig_in[2] = 1'b1;
    wait_until(t0 + 550);  sig_in[2] = 1'b0;
    wait_until(t0 + 900);  sig_in[2] = 1'b1;
    wait_until(t0 + 950);  sig_in[2] = 1'b0;
    wait_until(t0 + 1000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_ch", 32'(out_ch), 32'd2);
      check("held_period", 32'(out_period), 32'd200);
      check("held_flags", 32'(out_flags), 32'd0);
    end
    @(posedge clk);
    #2;
    push(2, 200, 0);
    push(2, 400, 2);
    out_ready = 1'b1;
    drain("ch2_overrun", 50);

    // ch3 saturation at 2^10-1, then a normal period
    ch_en = 4'b1000;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);        sig_in[3] = 1'b1;
    wait_until(t0 + 100);  sig_in[3] = 1'b0;
    wait_until(t0 + 1500); sig_in[3] = 1'b1; push(3, 1023, 1);
    wait_until(t0 + 1600); sig_in[3] = 1'b0;
    wait_until(t0 + 2100); sig_in[3] = 1'b1; push(3, 600, 0);
    drain("ch3_sat", 50);

    // Round-robin: all channels capture on one cycle
    ch_en = 4'b0000;
    sig_in = 4'b0000;
    tick(5);
    ch_en = 4'b1111;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);       sig_in = 4'b1111;
    wait_until(t0 + 20);  sig_in = 4'b0000;
    wait_until(t0 + 50);  sig_in = 4'b1111;
    for (int c = 0; c < 4; c++) push(c, 50, 0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_order", 32'(out_ch), 32'(c));
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    wait_until(t0 + 80);  sig_in = 4'b0000;
    wait_until(t0 + 110); sig_in = 4'b1111;
    for (int c = 0; c < 4; c++) push(c, 60, 0);
    drain("rr", 50);

    // Disable ch0 with a result pending; presented result survives
    ch_en = 4'b0000;
    sig_in = 4'b0000;
    tick(5);
    ch_en = 4'b0001;
    tick(5);
    out_ready = 1'b0;
    t0 = cyc + 1;
    wait_until(t0);       sig_in[0] = 1'b1;
    wait_until(t0 + 30);  sig_in[0] = 1'b0;
    wait_until(t0 + 100); sig_in[0] = 1'b1;
    wait_until(t0 + 130); sig_in[0] = 1'b0;
    wait_until(t0 + 250); sig_in[0] = 1'b1;
    wait_until(t0 + 260); ch_en = 4'b0000;
    wait_until(t0 + 262);
    check("dis_valid", 32'(out_valid), 32'd1);
    check("dis_ch", 32'(out_ch), 32'd0);
    check("dis_period", 32'(out_period), 32'd100);
    wait_until(t0 + 270); sig_in[0] = 1'b0;
    pulse_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      pulse_seen = pulse_seen | edge_pulse[0];
    end
    check("dis_pulse_suppressed", 32'(pulse_seen), 32'd0);
    @(posedge clk);
    #2;
    push(0, 100, 0);
    out_ready = 1'b1;
    drain("disable", 50);
    ch_en = 4'b0001;
    tick(5);
    t0 = cyc + 1;
    wait_until(t0);       sig_in[0] = 1'b1;
    wait_until(t0 + 40);  sig_in[0] = 1'b0;
    wait_until(t0 + 120); sig_in[0] = 1'b1; push(0, 120, 0);
    drain("reenable", 50);

    // Async reset with output valid and slots full
    ch_en = 4'b0000;
    sig_in = 4'b0000;
    tick(5);
    ch_en = 4'b1111;
    tick(5);
    out_ready = 1'b0;
    t0 = cyc + 1;
    wait_until(t0);       sig_in = 4'b1111;
    wait_until(t0 + 20);  sig_in = 4'b0000;
    wait_until(t0 + 60);  sig_in = 4'b1111;
    wait_until(t0 + 70);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_period", 32'(out_period), 32'd60);
    #1 rst = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    tick(30);
    check("post_rst_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
